// File: rtl/alu_pkg.sv
// Shared ALU types and constants for the add64 arbitration slice.
package alu_pkg;
  localparam int W        = 64;
  localparam int REQ_ID_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;
endpackage

// File: rtl/add64.sv
// 64-bit two's-complement adder with no carry-in; purely combinational.
// Reports signed overflow as carry into the MSB XOR carry out of it.
module add64
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         of
);
  logic         carry_out;
  logic         carry_msb;

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b};
  // Recover the carry into the MSB from that bit's sum equation.
  assign carry_msb = a[W-1] ^ b[W-1] ^ sum[W-1];
  assign of        = carry_msb ^ carry_out;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 over NREQ inputs.
// Grant is one-hot or zero; nothing is granted while en is low.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]     req,
  input  logic [REQ_ID_W-1:0] last_grant,
  input  logic                en,
  output logic [NREQ-1:0]     gnt,
  output logic [REQ_ID_W-1:0] gnt_idx
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NREQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = REQ_ID_W'(idx);
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/add64_arbiter.sv
// Shares one add64 among NREQ requesters round-robin; one op in flight, 2-cycle latency.
// Response is held until rsp_ready; no new grant is issued while a response is stalled.
module add64_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [REQ_ID_W-1:0] rsp_id,
  output logic [W-1:0]        rsp_sum,
  output logic                rsp_of,
  output logic                rsp_zf,
  output logic                rsp_sf
);
  arb_state_t          state_q, state_d;
  logic [REQ_ID_W-1:0] last_grant_q, last_grant_d;
  logic [W-1:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [REQ_ID_W-1:0] op_id_q, op_id_d;
  logic [REQ_ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]        rsp_sum_q, rsp_sum_d;
  logic                rsp_of_q, rsp_of_d, rsp_zf_q, rsp_zf_d, rsp_sf_q, rsp_sf_d;

  logic                arb_en;
  logic [NREQ-1:0]     gnt;
  logic [REQ_ID_W-1:0] gnt_idx;
  logic                gnt_any;
  logic [W-1:0]        add_sum;
  logic                add_of;

  // Grants happen from IDLE, or from RESP in the same cycle the response drains.
  assign arb_en  = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign gnt_any = |gnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  add64 u_add (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (add_sum),
    .of  (add_of)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_of_d     = rsp_of_q;
    rsp_zf_d     = rsp_zf_q;
    rsp_sf_d     = rsp_sf_q;

    if (gnt_any) begin
      last_grant_d = gnt_idx;
      op_id_d      = gnt_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          op_a_d = req_a[i*W +: W];
          op_b_d = req_b[i*W +: W];
        end
      end
    end

    case (state_q)
      IDLE: if (gnt_any) state_d = EXEC;
      EXEC: begin
        state_d   = RESP;
        rsp_id_d  = op_id_q;
        rsp_sum_d = add_sum;
        rsp_of_d  = add_of;
        rsp_zf_d  = (add_sum == '0);
        rsp_sf_d  = add_sum[W-1];
      end
      RESP: if (rsp_ready) state_d = gnt_any ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_ID_W'(NREQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_of_q     <= 1'b0;
      rsp_zf_q     <= 1'b0;
      rsp_sf_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_of_q     <= rsp_of_d;
      rsp_zf_q     <= rsp_zf_d;
      rsp_sf_q     <= rsp_sf_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_of    = rsp_of_q;
  assign rsp_zf    = rsp_zf_q;
  assign rsp_sf    = rsp_sf_q;
endmodule
